// File: rtl/sap_memory_address_register_n_if.sv
// Bus bundle for the SAP memory address register: address sources, burst
// handshake and the registered address/status outputs.
interface sap_memory_address_register_n_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  Prog;
  logic [ADDR_WIDTH-1:0] switch_addr;
  logic [ADDR_WIDTH-1:0] address_in;
  logic                  LMbar;
  logic                  INCbar;
  logic                  burst_start;
  logic [ADDR_WIDTH-1:0] burst_len;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] register;
  logic                  busy;
  logic                  burst_done;
  logic                  overflow;

  modport master (
    output Prog, switch_addr, address_in, LMbar, INCbar,
           burst_start, burst_len, ready,
    input  register, busy, burst_done, overflow
  );

  modport slave (
    input  Prog, switch_addr, address_in, LMbar, INCbar,
           burst_start, burst_len, ready,
    output register, busy, burst_done, overflow
  );
endinterface

// File: rtl/sap_memory_address_register_n.sv
// Parametrised SAP memory address register with load, program-mode tracking,
// single-step increment and a ready-handshaked burst walker.
module sap_memory_address_register_n #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RESET_ADDR = 0,
  parameter bit          WRAP_EN    = 1'b1
) (
  input logic Clk,
  input logic Clr,
  sap_memory_address_register_n_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [ADDR_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] RST_VAL  = ADDR_WIDTH'(RESET_ADDR);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_remain, w_remain_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic [ADDR_WIDTH:0]   w_inc;

  // MSB flags a saturated increment; the low bits are the next address.
  function automatic logic [ADDR_WIDTH:0] inc_addr(input logic [ADDR_WIDTH-1:0] a);
    if (!WRAP_EN && a == ALL_ONES)
      return {1'b1, a};
    else
      return {1'b0, a + ONE};
  endfunction

  assign w_inc = inc_addr(r_addr);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state  <= IDLE;
      r_addr   <= RST_VAL;
      r_remain <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_remain <= w_remain_nxt;
      r_done   <= w_done_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_remain_nxt = r_remain;
    w_done_nxt   = 1'b0;
    w_ovf_nxt    = r_ovf;
    if (bus.Prog) begin
      w_addr_nxt  = bus.switch_addr;
      w_state_nxt = IDLE;
    end else if (!bus.LMbar) begin
      w_addr_nxt  = bus.address_in;
      w_state_nxt = IDLE;
    end else if (r_state == BURST) begin
      if (bus.ready) begin
        // A captured length of 0 wraps to all-ones here, giving 2^N accepts.
        w_addr_nxt   = w_inc[ADDR_WIDTH-1:0];
        w_ovf_nxt    = r_ovf | w_inc[ADDR_WIDTH];
        w_remain_nxt = r_remain - ONE;
        if (r_remain == ONE) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    end else if (bus.burst_start) begin
      w_remain_nxt = bus.burst_len;
      w_state_nxt  = BURST;
    end else if (!bus.INCbar) begin
      w_addr_nxt = w_inc[ADDR_WIDTH-1:0];
      w_ovf_nxt  = r_ovf | w_inc[ADDR_WIDTH];
    end
  end

  assign bus.register   = r_addr;
  assign bus.busy       = (r_state == BURST);
  assign bus.burst_done = r_done;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_sap_memory_address_register_n.sv
// Directed bench for the SAP MAR: wrapping 4-bit, saturating 4-bit and 8-bit
// instances driven from one clock.
module tb_sap_memory_address_register_n;

  logic Clk = 1'b0;
  logic ClrA = 1'b0;
  logic ClrB = 1'b0;
  logic ClrC = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 Clk = ~Clk;

  sap_memory_address_register_n_if #(.ADDR_WIDTH(4)) ifa ();
  sap_memory_address_register_n_if #(.ADDR_WIDTH(4)) ifb ();
  sap_memory_address_register_n_if #(.ADDR_WIDTH(8)) ifc ();

  sap_memory_address_register_n #(.ADDR_WIDTH(4), .RESET_ADDR(0), .WRAP_EN(1'b1))
    u_dut_a (.Clk(Clk), .Clr(ClrA), .bus(ifa));
  sap_memory_address_register_n #(.ADDR_WIDTH(4), .RESET_ADDR(0), .WRAP_EN(1'b0))
    u_dut_b (.Clk(Clk), .Clr(ClrB), .bus(ifb));
  sap_memory_address_register_n #(.ADDR_WIDTH(8), .RESET_ADDR(0), .WRAP_EN(1'b1))
    u_dut_c (.Clk(Clk), .Clr(ClrC), .bus(ifc));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int acc;
    int dn;

    ifa.Prog = 0; ifa.switch_addr = 0; ifa.address_in = 0; ifa.LMbar = 1;
    ifa.INCbar = 1; ifa.burst_start = 0; ifa.burst_len = 0; ifa.ready = 0;
    ifb.Prog = 0; ifb.switch_addr = 0; ifb.address_in = 0; ifb.LMbar = 1;
    ifb.INCbar = 1; ifb.burst_start = 0; ifb.burst_len = 0; ifb.ready = 0;
    ifc.Prog = 0; ifc.switch_addr = 0; ifc.address_in = 0; ifc.LMbar = 1;
    ifc.INCbar = 1; ifc.burst_start = 0; ifc.burst_len = 0; ifc.ready = 0;

    // Reset takes effect without a clock edge.
    #2 ClrA = 1; ClrB = 1; ClrC = 1;
    #1;
    chk("rst_reg",  16'(ifa.register),   16'h0);
    chk("rst_busy", 16'(ifa.busy),       16'h0);
    chk("rst_done", 16'(ifa.burst_done), 16'h0);
    chk("rst_ovf",  16'(ifa.overflow),   16'h0);
    @(negedge Clk);
    ClrA = 0; ClrB = 0; ClrC = 0;

    // Load and hold.
    ifa.LMbar = 0; ifa.address_in = 4'hA;
    tick;
    chk("load_A", 16'(ifa.register), 16'hA);
    ifa.LMbar = 1; ifa.address_in = 4'h3;
    tick;
    chk("hold_A", 16'(ifa.register), 16'hA);

    // Program mode beats a simultaneous load.
    ifa.Prog = 1; ifa.switch_addr = 4'h7; ifa.LMbar = 0; ifa.address_in = 4'h2;
    tick;
    chk("prog_wins", 16'(ifa.register), 16'h7);
    ifa.Prog = 0; ifa.LMbar = 1;

    ifa.INCbar = 0;
    tick;
    chk("inc_7_8", 16'(ifa.register), 16'h8);
    ifa.INCbar = 1;

    // Burst of 3 from E with ready pattern 1,0,1,1 and wrap.
    ifa.LMbar = 0; ifa.address_in = 4'hE;
    tick;
    ifa.LMbar = 1;
    ifa.burst_start = 1; ifa.burst_len = 4'd3; ifa.ready = 0;
    tick;
    ifa.burst_start = 0;
    chk("bst_busy0", 16'(ifa.busy), 16'h1);
    chk("bst_first", 16'(ifa.register), 16'hE);
    ifa.ready = 1; ifa.INCbar = 0;
    tick;
    chk("bst_acc1", 16'(ifa.register), 16'hF);
    chk("bst_done1", 16'(ifa.burst_done), 16'h0);
    ifa.ready = 0;
    tick;
    chk("bst_stall", 16'(ifa.register), 16'hF);
    ifa.ready = 1;
    tick;
    chk("bst_acc2", 16'(ifa.register), 16'h0);
    chk("bst_done2", 16'(ifa.burst_done), 16'h0);
    tick;
    chk("bst_final", 16'(ifa.register), 16'h1);
    chk("bst_done", 16'(ifa.burst_done), 16'h1);
    chk("bst_idle", 16'(ifa.busy), 16'h0);
    chk("bst_noovf", 16'(ifa.overflow), 16'h0);
    ifa.INCbar = 1; ifa.ready = 0;
    tick;
    chk("bst_done_end", 16'(ifa.burst_done), 16'h0);
    chk("bst_hold", 16'(ifa.register), 16'h1);

    // Abort with a load after 3 accepts.
    ifa.LMbar = 0; ifa.address_in = 4'h0;
    tick;
    ifa.LMbar = 1;
    ifa.burst_start = 1; ifa.burst_len = 4'd8;
    tick;
    ifa.burst_start = 0; ifa.ready = 1;
    tick; tick; tick;
    chk("abt_pre", 16'(ifa.register), 16'h3);
    ifa.LMbar = 0; ifa.address_in = 4'hC;
    tick;
    ifa.LMbar = 1;
    chk("abt_reg", 16'(ifa.register), 16'hC);
    chk("abt_busy", 16'(ifa.busy), 16'h0);
    chk("abt_done", 16'(ifa.burst_done), 16'h0);
    tick;
    chk("abt_done2", 16'(ifa.burst_done), 16'h0);
    chk("abt_hold", 16'(ifa.register), 16'hC);

    // Asynchronous clear in the middle of a burst.
    ifa.LMbar = 0; ifa.address_in = 4'h5;
    tick;
    ifa.LMbar = 1; ifa.burst_start = 1; ifa.burst_len = 4'd4;
    tick;
    ifa.burst_start = 0;
    tick;
    chk("clr_pre", 16'(ifa.register), 16'h6);
    #2 ClrA = 1;
    #1;
    chk("clr_reg", 16'(ifa.register), 16'h0);
    chk("clr_busy", 16'(ifa.busy), 16'h0);
    @(negedge Clk);
    ClrA = 0; ifa.ready = 0;

    // Saturation with WRAP_EN=0.
    ifb.LMbar = 0; ifb.address_in = 4'hF;
    tick;
    ifb.LMbar = 1; ifb.INCbar = 0;
    tick;
    chk("sat_reg1", 16'(ifb.register), 16'hF);
    chk("sat_ovf1", 16'(ifb.overflow), 16'h1);
    tick;
    ifb.INCbar = 1;
    chk("sat_reg2", 16'(ifb.register), 16'hF);
    chk("sat_ovf2", 16'(ifb.overflow), 16'h1);
    tick;
    chk("sat_sticky", 16'(ifb.overflow), 16'h1);
    #2 ClrB = 1;
    #1;
    chk("sat_clr", 16'(ifb.overflow), 16'h0);
    @(negedge Clk);
    ClrB = 0;

    // Full-range burst on the 8-bit instance.
    ifc.burst_start = 1; ifc.burst_len = 8'd0; ifc.ready = 1;
    tick;
    ifc.burst_start = 0;
    acc = 0;
    dn = 0;
    for (int i = 0; i < 300; i++) begin
      if (ifc.busy) acc++;
      tick;
      if (ifc.burst_done) dn++;
      if (!ifc.busy) break;
    end
    tick;
    if (ifc.burst_done) dn++;
    tick;
    if (ifc.burst_done) dn++;
    chk("w8_accepts", 16'(acc), 16'd256);
    chk("w8_done", 16'(dn), 16'd1);
    chk("w8_reg", 16'(ifc.register), 16'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
